// File: rtl/plab2_proc_fetch_unit.sv
// Module: plab2_proc_fetch_unit
// Fetch front-end for the plab2 pipelined processors. Issues sequential imem
// reads, tracks outstanding requests against a credit limit of MAX_INFLIGHT,
// buffers responses together with their PCs and hands them to decode over a
// val/rdy port. A redirect from X squashes every response still in flight.
// Optional feature: define PLAB2_PROC_FETCH_PERF_EN to add the squash_count
// and stall_count performance counter outputs.

`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_,a_,d_) (3+(o_)+(a_)+$clog2((d_)/8)+(d_))
`endif
`ifndef VC_MEM_RESP_MSG_NBITS
`define VC_MEM_RESP_MSG_NBITS(o_,d_) (3+(o_)+2+$clog2((d_)/8)+(d_))
`endif

module plab2_proc_fetch_unit #(
  parameter int          MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'h00000200
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
`ifdef PLAB2_PROC_FETCH_PERF_EN
  output logic [31:0]                               squash_count,
  output logic [31:0]                               stall_count,
`endif
  output logic [`VC_MEM_REQ_MSG_NBITS(8,32,32)-1:0] imemreq_msg,
  output logic                                      imemreq_val,
  input  logic                                      imemreq_rdy,
  input  logic [`VC_MEM_RESP_MSG_NBITS(8,32)-1:0]   imemresp_msg,
  input  logic                                      imemresp_val,
  output logic                                      imemresp_rdy,
  input  logic                                      redirect_val,
  input  logic [31:0]                               redirect_pc,
  output logic                                      inst_val,
  input  logic                                      inst_rdy,
  output logic [31:0]                               inst_msg,
  output logic [31:0]                               inst_pc
);

  localparam int RESP_NBITS = `VC_MEM_RESP_MSG_NBITS(8,32);
  localparam int CW         = $clog2(MAX_INFLIGHT + 1);
  localparam int PW         = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  localparam logic [CW:0]   MAX_OCC  = (CW+1)'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_INFLIGHT - 1);

  // Fetch / response bookkeeping
  logic [31:0]   pc_f;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;

  // Response buffer: circular queue of {pc, inst}
  logic [31:0]   buf_pc   [MAX_INFLIGHT];
  logic [31:0]   buf_inst [MAX_INFLIGHT];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  // Handshake decode
  logic [CW:0]   occupancy;
  logic          credit_ok;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_keep;
  logic          resp_squash;
  logic          inst_fire;
  logic [31:0]   resp_data;
  logic          unused_resp_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Credit check, handshakes and output steering; imemreq_val is also held low
  // while reset_n is asserted so the request port is quiet during reset
  always_comb begin
    occupancy        = {1'b0, inflight} + {1'b0, count};
    credit_ok        = occupancy < MAX_OCC;
    imemreq_val      = reset_n && !redirect_val && credit_ok;
    imemreq_msg      = {3'd0, 8'd0, pc_f, 2'd0, 32'd0};
    req_fire         = imemreq_val && imemreq_rdy;
    imemresp_rdy     = 1'b1;
    resp_fire        = imemresp_val && imemresp_rdy;
    resp_data        = imemresp_msg[31:0];
    resp_keep        = resp_fire && !redirect_val && (drop_cnt == '0);
    resp_squash      = resp_fire && !resp_keep;
    inst_val         = (count != '0) && !redirect_val;
    inst_fire        = inst_val && inst_rdy;
    inst_msg         = buf_inst[head];
    inst_pc          = buf_pc[head];
    unused_resp_bits = ^imemresp_msg[RESP_NBITS-1:32];
  end

  // Control state: fetch PC, response PC, in-flight/drop counters and queue
  // pointers. On a redirect every outstanding response (already-doomed ones
  // included, since inflight counts them too) becomes a drop, which keeps
  // back-to-back redirects from double counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_f     <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_val) begin
      pc_f     <= redirect_pc;
      resp_pc  <= redirect_pc;
      inflight <= inflight - CW'(resp_fire);
      drop_cnt <= inflight - CW'(resp_fire);
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (req_fire) begin
        pc_f <= pc_f + 32'd4;
      end
      if (req_fire && !resp_fire) begin
        inflight <= inflight + CNT_ONE;
      end else if (!req_fire && resp_fire) begin
        inflight <= inflight - CNT_ONE;
      end
      if (resp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_ONE;
      end
      if (resp_keep) begin
        tail    <= ptr_inc(tail);
        resp_pc <= resp_pc + 32'd4;
      end
      if (inst_fire) begin
        head <= ptr_inc(head);
      end
      if (resp_keep && !inst_fire) begin
        count <= count + CNT_ONE;
      end else if (!resp_keep && inst_fire) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Buffer storage: write the accepted response at the tail slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
      end
    end else if (resp_keep) begin
      buf_pc[tail]   <= resp_pc;
      buf_inst[tail] <= resp_data;
    end
  end

`ifdef PLAB2_PROC_FETCH_PERF_EN
  // Performance counters: discarded responses and credit-limited issue cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash_count <= '0;
      stall_count  <= '0;
    end else begin
      squash_count <= squash_count + 32'(resp_squash);
      stall_count  <= stall_count + 32'(!redirect_val && !credit_ok);
    end
  end
`endif

endmodule

// File: tb/tb_plab2_proc_fetch_unit.sv
// Testbench: plab2_proc_fetch_unit with default parameters. A 1-cycle latency
// imem is modelled in the bench; instruction words are addr ^ 32'hCAFE0000.
module tb_plab2_proc_fetch_unit;

  localparam int REQ_NBITS  = 77;
  localparam int RESP_NBITS = 47;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b1;
`ifdef PLAB2_PROC_FETCH_PERF_EN
  logic [31:0]           squash_count;
  logic [31:0]           stall_count;
`endif
  logic [REQ_NBITS-1:0]  imemreq_msg;
  logic                  imemreq_val;
  logic                  imemreq_rdy = 1'b1;
  logic [RESP_NBITS-1:0] imemresp_msg = '0;
  logic                  imemresp_val = 1'b0;
  logic                  imemresp_rdy;
  logic                  redirect_val = 1'b0;
  logic [31:0]           redirect_pc = '0;
  logic                  inst_val;
  logic                  inst_rdy = 1'b0;
  logic [31:0]           inst_msg;
  logic [31:0]           inst_pc;

  int          vectors = 0;
  int          miscompares = 0;
  int          req_count = 0;
  logic        resp_hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_msg[$];

  always #5 clk = ~clk;

  plab2_proc_fetch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef PLAB2_PROC_FETCH_PERF_EN
    .squash_count (squash_count),
    .stall_count  (stall_count),
`endif
    .imemreq_msg  (imemreq_msg),
    .imemreq_val  (imemreq_val),
    .imemreq_rdy  (imemreq_rdy),
    .imemresp_msg (imemresp_msg),
    .imemresp_val (imemresp_val),
    .imemresp_rdy (imemresp_rdy),
    .redirect_val (redirect_val),
    .redirect_pc  (redirect_pc),
    .inst_val     (inst_val),
    .inst_rdy     (inst_rdy),
    .inst_msg     (inst_msg),
    .inst_pc      (inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic driveResp();
    if (reset_n && !resp_hold && pend.size() > 0) begin
      imemresp_val = 1'b1;
      imemresp_msg = {15'd0, mem_word(pend[0])};
    end else begin
      imemresp_val = 1'b0;
      imemresp_msg = '0;
    end
  endtask

  task automatic stepCycle();
    logic        req_fire;
    logic        resp_fire;
    logic        deq;
    logic [31:0] req_addr;
    logic [31:0] dq_pc;
    logic [31:0] dq_msg;
    #1;
    req_fire  = imemreq_val && imemreq_rdy;
    req_addr  = imemreq_msg[65:34];
    resp_fire = imemresp_val && imemresp_rdy;
    deq       = inst_val && inst_rdy;
    dq_pc     = inst_pc;
    dq_msg    = inst_msg;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      pend.delete();
    end else begin
      if (resp_fire) void'(pend.pop_front());
      if (req_fire) begin
        pend.push_back(req_addr);
        req_count++;
      end
      if (deq) begin
        got_pc.push_back(dq_pc);
        got_msg.push_back(dq_msg);
      end
    end
    @(negedge clk);
    driveResp();
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) stepCycle();
  endtask

  task automatic runUntil(input string tag, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (got_pc.size() < n && cyc < budget) begin
      stepCycle();
      cyc++;
    end
    checkOutput({tag, "_delivered"}, 32'(got_pc.size() >= n), 32'd1);
  endtask

  task automatic checkStream(input string tag, input logic [31:0] start, input int n);
    logic [31:0] exp_pc;
    for (int i = 0; i < n; i++) begin
      exp_pc = start + 32'(4 * i);
      checkOutput($sformatf("%s_pc%0d", tag, i),
                  (i < got_pc.size()) ? got_pc[i] : 32'hFFFF_FFFF, exp_pc);
      checkOutput($sformatf("%s_msg%0d", tag, i),
                  (i < got_msg.size()) ? got_msg[i] : 32'hFFFF_FFFF, mem_word(exp_pc));
    end
  endtask

  task automatic doReset(input logic hold);
    reset_n      = 1'b0;
    redirect_val = 1'b0;
    redirect_pc  = '0;
    inst_rdy     = 1'b0;
    resp_hold    = hold;
    req_count    = 0;
    pend.delete();
    got_pc.delete();
    got_msg.delete();
    driveResp();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    driveResp();
  endtask

  initial begin
    #2;
    reset_n = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_req_val", imemreq_val, 32'd0);
    checkOutput("rst_inst_val", inst_val, 32'd0);
    checkOutput("rst_resp_rdy", imemresp_rdy, 32'd1);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_inst_msg", inst_msg, 32'd0);

    $display("[TB] test 1: sequential fetch");
    doReset(1'b0);
    inst_rdy = 1'b1;
    #1;
    checkOutput("t1_req_val", imemreq_val, 32'd1);
    checkOutput("t1_req_addr", imemreq_msg[65:34], 32'h200);
    checkOutput("t1_inst_val_empty", inst_val, 32'd0);
    stepCycle();
    stepCycle();
    #1;
    checkOutput("t1_inst_val", inst_val, 32'd1);
    checkOutput("t1_inst_pc", inst_pc, 32'h200);
    checkOutput("t1_inst_msg", inst_msg, 32'hCAFE0200);
    checkOutput("t1_credit_stall", imemreq_val, 32'd0);
    runUntil("t1", 4, 20);
    checkStream("t1", 32'h200, 4);

    $display("[TB] test 2: decode stalled");
    doReset(1'b0);
    applyStimulus(10);
    checkOutput("t2_req_count", 32'(req_count), 32'd2);
    checkOutput("t2_req_val_blocked", imemreq_val, 32'd0);
    checkOutput("t2_head_pc", inst_pc, 32'h200);
`ifdef PLAB2_PROC_FETCH_PERF_EN
    checkOutput("t2_stall_count", stall_count, 32'd8);
`endif
    inst_rdy = 1'b1;
    runUntil("t2", 4, 30);
    checkStream("t2", 32'h200, 4);

    $display("[TB] test 3: redirect squashes two in flight");
    doReset(1'b1);
    inst_rdy = 1'b1;
    applyStimulus(2);
    checkOutput("t3_inflight_full", imemreq_val, 32'd0);
    redirect_val = 1'b1;
    redirect_pc  = 32'h300;
    #1;
    checkOutput("t3_redir_inst_val", inst_val, 32'd0);
    stepCycle();
    redirect_val = 1'b0;
    resp_hold    = 1'b0;
    driveResp();
    runUntil("t3", 3, 30);
    checkStream("t3", 32'h300, 3);
`ifdef PLAB2_PROC_FETCH_PERF_EN
    checkOutput("t3_squash_count", squash_count, 32'd2);
`endif

    $display("[TB] test 4: response on the redirect cycle");
    doReset(1'b1);
    inst_rdy = 1'b1;
    applyStimulus(2);
    resp_hold    = 1'b0;
    redirect_val = 1'b1;
    redirect_pc  = 32'h380;
    driveResp();
    #1;
    checkOutput("t4_resp_val", imemresp_val, 32'd1);
    checkOutput("t4_redir_req_val", imemreq_val, 32'd0);
    stepCycle();
    redirect_val = 1'b0;
    runUntil("t4", 2, 20);
    checkStream("t4", 32'h380, 2);
`ifdef PLAB2_PROC_FETCH_PERF_EN
    checkOutput("t4_squash_count", squash_count, 32'd2);
`endif

    $display("[TB] test 5a: consecutive redirects over a full buffer");
    doReset(1'b0);
    applyStimulus(5);
    checkOutput("t5a_inst_val_full", inst_val, 32'd1);
    redirect_val = 1'b1;
    redirect_pc  = 32'h300;
    #1;
    checkOutput("t5a_redir_inst_val", inst_val, 32'd0);
    checkOutput("t5a_redir_req_val", imemreq_val, 32'd0);
    stepCycle();
    redirect_pc = 32'h400;
    stepCycle();
    redirect_val = 1'b0;
    inst_rdy     = 1'b1;
    runUntil("t5a", 3, 30);
    checkStream("t5a", 32'h400, 3);

    $display("[TB] test 5b: consecutive redirects with requests in flight");
    doReset(1'b1);
    inst_rdy = 1'b1;
    applyStimulus(2);
    redirect_val = 1'b1;
    redirect_pc  = 32'h300;
    stepCycle();
    redirect_pc = 32'h400;
    stepCycle();
    redirect_val = 1'b0;
    resp_hold    = 1'b0;
    driveResp();
    runUntil("t5b", 3, 30);
    checkStream("t5b", 32'h400, 3);

    $display("[TB] test 6: reset mid-stream");
    doReset(1'b0);
    applyStimulus(5);
    #1;
    checkOutput("t6_inst_val_full", inst_val, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_inst_val", inst_val, 32'd0);
    checkOutput("t6_async_inst_pc", inst_pc, 32'd0);
    checkOutput("t6_async_inst_msg", inst_msg, 32'd0);
    checkOutput("t6_async_req_val", imemreq_val, 32'd0);
    pend.delete();
    got_pc.delete();
    got_msg.delete();
    driveResp();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    driveResp();
    inst_rdy = 1'b1;
    runUntil("t6", 2, 20);
    checkStream("t6", 32'h200, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
